// File: rtl/rx_link_ctrl_pkg.sv
// Shared types and helpers for the RX link acquisition/tracking sequencer.
// State and frame-sync codes are visible on the status outputs, so their encodings are fixed.
package rx_link_ctrl_pkg;

   localparam int THR_W = 24;
   localparam int NRL_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEARCH    = 3'd1,
      ST_LOCK_WAIT = 3'd2,
      ST_TRACK     = 3'd3,
      ST_RELOCK    = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      FS_OFF     = 2'd0,
      FS_SEARCH  = 2'd1,
      FS_CONFIRM = 2'd2,
      FS_TRACK   = 2'd3
   } frsync_e;

   function automatic frsync_e frsync_of(input state_e st);
      frsync_e fs;
      fs = FS_OFF;
      case (st)
         ST_SEARCH:    fs = FS_SEARCH;
         ST_LOCK_WAIT: fs = FS_CONFIRM;
         ST_TRACK:     fs = FS_TRACK;
         default:      fs = FS_OFF;
      endcase
      return fs;
   endfunction

   // Step down by one decrement, clamping at the floor instead of wrapping.
   function automatic logic [THR_W-1:0] thr_dec(input logic [THR_W-1:0] thr,
                                                input logic [THR_W-1:0] step,
                                                input logic [THR_W-1:0] floor);
      logic [THR_W:0] lim;
      lim = {1'b0, floor} + {1'b0, step};
      if ({1'b0, thr} >= lim) return thr - step;
      return floor;
   endfunction

endpackage

// File: rtl/crc_run_cnt.sv
// Consecutive-event run counter: counts inc pulses, restarts on zero or clr,
// saturates at TARGET and flags the pulse that completes the run.
module crc_run_cnt #(
   parameter int CNT_W  = 3,
   parameter int TARGET = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   input  logic zero,
   output logic reached
);

   localparam logic [CNT_W-1:0] TGT    = CNT_W'(TARGET);
   localparam logic [CNT_W-1:0] TGT_M1 = CNT_W'(TARGET - 1);

   logic [CNT_W-1:0] cnt;

   // Combinational so the owner can change state on the same edge that samples the pulse.
   assign reached = inc && (cnt >= TGT_M1);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr || zero) begin
         cnt <= '0;
      end else if (inc && (cnt != TGT)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/rx_link_ctrl.sv
// RX link sequencer: threshold search, lock confirmation by CRC runs, tracking,
// and datapath-reset relock. All outputs are registered from the next-state decode.
module rx_link_ctrl
   import rx_link_ctrl_pkg::*;
#(
   parameter logic [THR_W-1:0] THR_INIT = 24'h040000,
   parameter logic [THR_W-1:0] THR_STEP = 24'h004000,
   parameter logic [THR_W-1:0] THR_MIN  = 24'h008000,
   parameter int SEARCH_TO = 1000000,
   parameter int LOCK_TO   = 4000000,
   parameter int LOCK_N    = 4,
   parameter int LOSS_N    = 3,
   parameter int RST_LEN   = 16,
   parameter int TMR_W     = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             thr_mode,
   input  logic [THR_W-1:0] thr_lvl_auto,
   input  logic             corr_pr_detect,
   input  logic             decrc_verr,
   input  logic             decrc_oerr,
   output logic [THR_W-1:0] thr_lvl,
   output logic [1:0]       frsync_ctrl,
   output logic             dp_rst,
   output logic             lock,
   output logic [2:0]       state_o,
   output logic [NRL_W-1:0] n_relock
);

   localparam int CNT_MAX = (LOCK_N > LOSS_N) ? LOCK_N : LOSS_N;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [TMR_W-1:0] SEARCH_LAST = TMR_W'(SEARCH_TO - 1);
   localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_TO - 1);
   localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_LEN - 1);

   state_e           state, state_d;
   logic [TMR_W-1:0] timer, timer_d;
   logic [THR_W-1:0] thr_srch, thr_srch_d;
   logic             crc_good, crc_bad, good_hit, bad_hit;
   logic             in_confirm, in_crc_watch, changing, search_to;
   logic [THR_W-1:0] thr_lvl_d;
   logic [1:0]       frsync_d;
   logic             dp_rst_d, lock_d;
   logic [NRL_W-1:0] n_relock_d;

   assign crc_good     = decrc_verr & ~decrc_oerr;
   assign crc_bad      = decrc_verr &  decrc_oerr;
   assign in_confirm   = (state == ST_LOCK_WAIT);
   assign in_crc_watch = (state == ST_LOCK_WAIT) || (state == ST_TRACK);
   assign changing     = (state_d != state);
   assign search_to    = (timer == SEARCH_LAST);
   assign state_o      = state;

   // Run counters restart on every state change so each phase starts from a clean count.
   crc_run_cnt #(.CNT_W(CNT_W), .TARGET(LOCK_N)) u_good (
      .clk     (clk),
      .rst     (rst),
      .clr     (changing | ~in_confirm),
      .inc     (crc_good & in_confirm),
      .zero    (crc_bad),
      .reached (good_hit)
   );

   crc_run_cnt #(.CNT_W(CNT_W), .TARGET(LOSS_N)) u_bad (
      .clk     (clk),
      .rst     (rst),
      .clr     (changing | ~in_crc_watch),
      .inc     (crc_bad & in_crc_watch),
      .zero    (crc_good),
      .reached (bad_hit)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         timer    <= '0;
         thr_srch <= THR_INIT;
      end else begin
         state    <= state_d;
         timer    <= timer_d;
         thr_srch <= thr_srch_d;
      end
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state;
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:      state_d = ST_SEARCH;
            ST_SEARCH:    if (corr_pr_detect) state_d = ST_LOCK_WAIT;
            ST_LOCK_WAIT: begin
               if (good_hit)                             state_d = ST_TRACK;
               else if (bad_hit || (timer == LOCK_LAST)) state_d = ST_RELOCK;
            end
            ST_TRACK:     if (bad_hit) state_d = ST_RELOCK;
            ST_RELOCK:    if (timer == RST_LAST) state_d = ST_SEARCH;
            default:      state_d = ST_IDLE;
         endcase
      end
   end

   // One timer serves the search timeout, the lock-wait timeout and the relock pulse length.
   always_comb begin
      timer_d = '0;
      if (!changing) begin
         case (state)
            ST_SEARCH:               timer_d = search_to ? '0 : timer + TMR_W'(1);
            ST_LOCK_WAIT, ST_RELOCK: timer_d = timer + TMR_W'(1);
            default:                 timer_d = '0;
         endcase
      end
   end

   always_comb begin
      thr_srch_d = thr_srch;
      if ((state_d == ST_IDLE) || (state_d == ST_RELOCK)) begin
         thr_srch_d = THR_INIT;
      end else if ((state == ST_SEARCH) && !changing && search_to) begin
         thr_srch_d = thr_dec(thr_srch, THR_STEP, THR_MIN);
      end
   end

   // The internal threshold keeps stepping in auto mode so switching back never glitches.
   always_comb begin
      thr_lvl_d  = thr_mode ? thr_lvl_auto : thr_srch_d;
      frsync_d   = frsync_of(state_d);
      dp_rst_d   = (state_d != ST_RELOCK);
      lock_d     = (state_d == ST_TRACK);
      n_relock_d = n_relock;
      if ((state_d == ST_RELOCK) && (state != ST_RELOCK) && (n_relock != '1)) begin
         n_relock_d = n_relock + NRL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         thr_lvl     <= THR_INIT;
         frsync_ctrl <= FS_OFF;
         dp_rst      <= 1'b1;
         lock        <= 1'b0;
         n_relock    <= '0;
      end else begin
         thr_lvl     <= thr_lvl_d;
         frsync_ctrl <= frsync_d;
         dp_rst      <= dp_rst_d;
         lock        <= lock_d;
         n_relock    <= n_relock_d;
      end
   end

endmodule

// File: tb/tb_rx_link_ctrl.sv
// Directed bench for rx_link_ctrl with shortened timeouts; expected values are hand-computed
// cycle counts from the point each state is entered.
module tb_rx_link_ctrl;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        thr_mode;
   logic [23:0] thr_lvl_auto;
   logic        corr_pr_detect;
   logic        decrc_verr;
   logic        decrc_oerr;
   logic [23:0] thr_lvl;
   logic [1:0]  frsync_ctrl;
   logic        dp_rst;
   logic        lock;
   logic [2:0]  state_o;
   logic [15:0] n_relock;

   int n_cmp  = 0;
   int n_fail = 0;
   int low_cnt;

   rx_link_ctrl #(
      .SEARCH_TO (20),
      .LOCK_TO   (100),
      .LOCK_N    (4),
      .LOSS_N    (3),
      .RST_LEN   (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .thr_mode       (thr_mode),
      .thr_lvl_auto   (thr_lvl_auto),
      .corr_pr_detect (corr_pr_detect),
      .decrc_verr     (decrc_verr),
      .decrc_oerr     (decrc_oerr),
      .thr_lvl        (thr_lvl),
      .frsync_ctrl    (frsync_ctrl),
      .dp_rst         (dp_rst),
      .lock           (lock),
      .state_o        (state_o),
      .n_relock       (n_relock)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic detect();
      corr_pr_detect = 1'b1;
      tick();
      corr_pr_detect = 1'b0;
   endtask

   task automatic crc(input logic err);
      decrc_verr = 1'b1;
      decrc_oerr = err;
      tick();
      decrc_verr = 1'b0;
      decrc_oerr = 1'b0;
   endtask

   initial begin
      rst            = 1'b0;
      enable         = 1'b0;
      thr_mode       = 1'b0;
      thr_lvl_auto   = 24'h0;
      corr_pr_detect = 1'b0;
      decrc_verr     = 1'b0;
      decrc_oerr     = 1'b0;
      ticks(2);
      check("rst_state",    32'(state_o),     32'd0);
      check("rst_thr",      32'(thr_lvl),     32'h040000);
      check("rst_frsync",   32'(frsync_ctrl), 32'd0);
      check("rst_dp_rst",   32'(dp_rst),      32'd1);
      check("rst_lock",     32'(lock),        32'd0);
      check("rst_n_relock", 32'(n_relock),    32'd0);

      // Acquisition: IDLE -> SEARCH -> LOCK_WAIT -> TRACK; a bad CRC restarts the good run.
      rst    = 1'b1;
      enable = 1'b1;
      tick();
      check("search_state",  32'(state_o),     32'd1);
      check("search_frsync", 32'(frsync_ctrl), 32'd1);
      ticks(8);
      detect();
      check("lw_state",  32'(state_o),     32'd2);
      check("lw_frsync", 32'(frsync_ctrl), 32'd2);
      crc(1'b0); crc(1'b0); crc(1'b0);
      check("lw_3good_state", 32'(state_o), 32'd2);
      check("lw_3good_lock",  32'(lock),    32'd0);
      crc(1'b1);
      crc(1'b0); crc(1'b0); crc(1'b0);
      check("lw_run_restart", 32'(state_o), 32'd2);
      crc(1'b0);
      check("track_state",  32'(state_o),     32'd3);
      check("track_lock",   32'(lock),        32'd1);
      check("track_frsync", 32'(frsync_ctrl), 32'd3);
      detect();
      check("track_ignore_det", 32'(state_o), 32'd3);

      // Loss in TRACK needs three consecutive bad CRCs.
      crc(1'b1); crc(1'b0); crc(1'b1); crc(1'b1);
      check("track_2bad_state", 32'(state_o), 32'd3);
      check("track_2bad_lock",  32'(lock),    32'd1);
      crc(1'b1);
      check("relock_state",    32'(state_o),     32'd4);
      check("relock_lock",     32'(lock),        32'd0);
      check("relock_dp_rst",   32'(dp_rst),      32'd0);
      check("relock_frsync",   32'(frsync_ctrl), 32'd0);
      check("relock_n_relock", 32'(n_relock),    32'd1);
      check("relock_thr",      32'(thr_lvl),     32'h040000);
      low_cnt = 1;
      for (int i = 0; i < 16; i++) begin
         corr_pr_detect = (i == 3);
         tick();
         corr_pr_detect = 1'b0;
         if (dp_rst == 1'b0) low_cnt++;
      end
      check("relock_low_len",  32'(low_cnt),  32'd16);
      check("relock_exit",     32'(state_o),  32'd1);
      check("relock_dp_high",  32'(dp_rst),   32'd1);
      check("relock_cnt_hold", 32'(n_relock), 32'd1);

      // Detect in the timeout cycle: LOCK_WAIT wins and the threshold does not step.
      ticks(19);
      check("pre_to_thr", 32'(thr_lvl), 32'h040000);
      detect();
      check("det_to_state", 32'(state_o), 32'd2);
      check("det_to_thr",   32'(thr_lvl), 32'h040000);

      // LOCK_WAIT with no CRC verdicts times out after 100 cycles.
      ticks(99);
      check("lw_to_99", 32'(state_o), 32'd2);
      tick();
      check("lw_to_100",      32'(state_o),  32'd4);
      check("lw_to_n_relock", 32'(n_relock), 32'd2);
      ticks(16);
      check("lw_to_research", 32'(state_o), 32'd1);

      // Threshold search steps every 20 cycles and clamps at the floor.
      for (int i = 1; i <= 320; i++) begin
         tick();
         case (i)
            19:  check("thr_19",  32'(thr_lvl), 32'h040000);
            20:  check("thr_20",  32'(thr_lvl), 32'h03C000);
            40:  check("thr_40",  32'(thr_lvl), 32'h038000);
            60:  check("thr_60",  32'(thr_lvl), 32'h034000);
            70:  check("thr_70",  32'(thr_lvl), 32'h034000);
            260: check("thr_260", 32'(thr_lvl), 32'h00C000);
            280: check("thr_280", 32'(thr_lvl), 32'h008000);
            320: check("thr_320", 32'(thr_lvl), 32'h008000);
            default: ;
         endcase
      end
      check("thr_search_state", 32'(state_o), 32'd1);

      // Bad CRC run in LOCK_WAIT forces RELOCK and re-initialises the threshold.
      detect();
      check("lw2_thr_hold", 32'(thr_lvl), 32'h008000);
      crc(1'b1); crc(1'b1);
      check("lw2_2bad", 32'(state_o), 32'd2);
      crc(1'b1);
      check("lw2_3bad_state", 32'(state_o),  32'd4);
      check("lw2_3bad_thr",   32'(thr_lvl),  32'h040000);
      check("lw2_n_relock",   32'(n_relock), 32'd3);

      // enable=0 during RELOCK, then auto threshold mode.
      ticks(4);
      enable = 1'b0;
      tick();
      check("dis_state",    32'(state_o),  32'd0);
      check("dis_dp_rst",   32'(dp_rst),   32'd1);
      check("dis_n_relock", 32'(n_relock), 32'd3);
      check("dis_lock",     32'(lock),     32'd0);
      thr_mode     = 1'b1;
      thr_lvl_auto = 24'h123456;
      check("auto_pre", 32'(thr_lvl), 32'h040000);
      tick();
      check("auto_1", 32'(thr_lvl), 32'h123456);
      thr_lvl_auto = 24'h0ABCDE;
      enable       = 1'b1;
      tick();
      check("auto_2",       32'(thr_lvl), 32'h0ABCDE);
      check("auto_2_state", 32'(state_o), 32'd1);
      thr_mode = 1'b0;
      tick();
      check("auto_off", 32'(thr_lvl), 32'h040000);

      // Asynchronous reset in the middle of RELOCK releases dp_rst without a clock.
      detect();
      crc(1'b1); crc(1'b1); crc(1'b1);
      check("ar_relock_dp", 32'(dp_rst), 32'd0);
      #2 rst = 1'b0;
      #1;
      check("ar_dp_rst",   32'(dp_rst),   32'd1);
      check("ar_state",    32'(state_o),  32'd0);
      check("ar_n_relock", 32'(n_relock), 32'd0);
      tick();
      rst = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
